// File: rtl/conv_pkg.sv
// Shared encodings for the 3x3 convolution window feeder: pixel width default,
// compute-mux column phases and feeder FSM states.
package conv_pkg;

  localparam int DW_DEFAULT = 8;

  localparam logic [1:0] SEL_C0 = 2'd0;
  localparam logic [1:0] SEL_C1 = 2'd1;
  localparam logic [1:0] SEL_C2 = 2'd2;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_SEQ0   = 2'd1,
    ST_SEQ1   = 2'd2,
    ST_SEQ2   = 2'd3
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage, addressed circularly by column.
// Combinational read-before-write: dout shows the value from one row earlier.
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Forms 3x3 sliding windows from a row-major pixel stream and steps the
// downstream per-row multiplier muxes through three column phases per window.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] image_data0,
  output logic [DW-1:0] image_data1,
  output logic [DW-1:0] image_data2,
  output logic [DW-1:0] image_data3,
  output logic [DW-1:0] image_data4,
  output logic [DW-1:0] image_data5,
  output logic [DW-1:0] image_data6,
  output logic [DW-1:0] image_data7,
  output logic [DW-1:0] image_data8,
  output logic [1:0]    select,
  output logic          win_valid,
  output logic          frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] win [9];
  logic [DW-1:0] lb0_out, lb1_out;
  logic          accept, at_win, at_last, last_win;

  assign in_ready = rst && (state == ST_ACCEPT);
  assign accept   = in_valid && in_ready;
  assign at_win   = (row >= RW'(2)) && (col >= CW'(2));
  assign at_last  = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  // lb0 holds row r-1, lb1 holds row r-2 at the current column
  line_buffer #(.DEPTH(IMG_W), .DW(DW)) lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .din  (in_data),
    .dout (lb0_out)
  );

  line_buffer #(.DEPTH(IMG_W), .DW(DW)) lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window shifts left one column per accepted pixel; frozen during SEQ phases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb1_out;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb0_out;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_ACCEPT;
      last_win   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == ST_SEQ2) && last_win;
      if (accept && at_last)        last_win <= 1'b1;
      else if (state == ST_SEQ2)    last_win <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    select    = SEL_C0;
    win_valid = 1'b0;
    case (state)
      ST_ACCEPT: if (in_valid && at_win) state_nxt = ST_SEQ0;
      ST_SEQ0: begin
        select    = SEL_C0;
        win_valid = 1'b1;
        state_nxt = ST_SEQ1;
      end
      ST_SEQ1: begin
        select    = SEL_C1;
        win_valid = 1'b1;
        state_nxt = ST_SEQ2;
      end
      ST_SEQ2: begin
        select    = SEL_C2;
        win_valid = 1'b1;
        state_nxt = ST_ACCEPT;
      end
      default: state_nxt = ST_ACCEPT;
    endcase
  end

  assign image_data0 = win[0];
  assign image_data1 = win[1];
  assign image_data2 = win[2];
  assign image_data3 = win[3];
  assign image_data4 = win[4];
  assign image_data5 = win[5];
  assign image_data6 = win[6];
  assign image_data7 = win[7];
  assign image_data8 = win[8];

endmodule
